// File: rtl/product_accumulator.sv
// Sums BURST consecutive 8-bit unsigned products into an ACC_W-bit accumulator and
// holds each completed sum until the consumer takes it. Carry-out sets a sticky overflow flag.
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int BURST = 4,
  parameter int CNT_W = $clog2(BURST+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       product_low,
  input  logic [3:0]       product_high,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W:0]   p_ext;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             last;

  // clear wins over an accept presented in the same cycle
  assign accept  = (state_q == ACCUM) && in_valid && !clear;
  assign p_ext   = {{(ACC_W-7){1'b0}}, product_high, product_low};
  assign sum     = {1'b0, acc_q} + p_ext;
  assign cnt_inc = cnt_q + 1'b1;
  assign last    = (cnt_inc == CNT_W'(BURST));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (accept && last) state_d = HOLD;
        HOLD:    if (out_ready)      state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear || (state_q == HOLD && out_ready)) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      acc_d = sum[ACC_W-1:0];
      cnt_d = cnt_inc;
      ovf_d = ovf_q | sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_out  = acc_q;
  assign count    = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default ACC_W=12 instance and an ACC_W=9
// instance share stimulus; the narrow one exercises wrap-around and the overflow flag.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] product_low, product_high;
  logic       in_valid, clear, out_ready;

  logic [11:0] acc;
  logic [2:0]  cnt;
  logic        ovf, in_rdy, out_vld;
  logic [8:0]  acc9;
  logic [2:0]  cnt9;
  logic        ovf9, in_rdy9, out_vld9;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .product_low(product_low), .product_high(product_high),
    .in_valid(in_valid), .in_ready(in_rdy), .clear(clear), .acc_out(acc), .count(cnt),
    .overflow(ovf), .out_valid(out_vld), .out_ready(out_ready)
  );

  product_accumulator #(.ACC_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .product_low(product_low), .product_high(product_high),
    .in_valid(in_valid), .in_ready(in_rdy9), .clear(clear), .acc_out(acc9), .count(cnt9),
    .overflow(ovf9), .out_valid(out_vld9), .out_ready(out_ready)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] p);
    in_valid = v;
    {product_high, product_low} = p;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0; drive(1'b0, 8'h00);
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({acc, cnt, ovf, out_vld, in_rdy} !== {12'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset: acc=%0d cnt=%0d ovf=%b ov=%b ir=%b, want 0 0 0 0 1",
               acc, cnt, ovf, out_vld, in_rdy);
    end
  endtask

  task automatic test_burst();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'hE1);
      cyc();
      tests++;
      if (acc !== 12'(225*i) || cnt !== 3'(i) || ovf !== 1'b0 ||
          out_vld !== (i == 4) || in_rdy !== (i != 4)) begin
        fails++;
        $display("FAIL burst[%0d]: acc=%0d cnt=%0d ovf=%b ov=%b ir=%b, want acc=%0d cnt=%0d ov=%b",
                 i, acc, cnt, ovf, out_vld, in_rdy, 225*i, i, i == 4);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      drive(i[0] == 1'b0, 8'($urandom_range(0, 255)));
      cyc();
      tests++;
      if (acc !== 12'h384 || cnt !== 3'd4 || out_vld !== 1'b1 || in_rdy !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d]: acc=%0h cnt=%0d ov=%b ir=%b, want 384 4 1 0",
                 i, acc, cnt, out_vld, in_rdy);
      end
    end
    drive(1'b0, 8'h00);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    tests++;
    if (acc !== 12'd0 || cnt !== 3'd0 || in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      fails++;
      $display("FAIL handshake: acc=%0d cnt=%0d ir=%b ov=%b, want 0 0 1 0", acc, cnt, in_rdy, out_vld);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] exp_acc [4] = '{9'd225, 9'd450, 9'd163, 9'd388};
    logic       exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'd225);
      cyc();
      tests++;
      if (acc9 !== exp_acc[i] || ovf9 !== exp_ovf[i]) begin
        fails++;
        $display("FAIL wrap[%0d]: acc9=%0d ovf9=%b, want %0d %b", i, acc9, ovf9, exp_acc[i], exp_ovf[i]);
      end
    end
    tests++;
    if (out_vld9 !== 1'b1 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL wrap_done: ov9=%b ovf12=%b, want 1 0", out_vld9, ovf);
    end
    drive(1'b0, 8'h00);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    tests++;
    if (ovf9 !== 1'b0 || acc9 !== 9'd0 || in_rdy9 !== 1'b1) begin
      fails++;
      $display("FAIL wrap_clr: ovf9=%b acc9=%0d ir9=%b, want 0 0 1", ovf9, acc9, in_rdy9);
    end
  endtask

  task automatic test_clear();
    drive(1'b1, 8'd3); cyc();
    drive(1'b1, 8'd5); cyc();
    tests++;
    if (acc !== 12'd8 || cnt !== 3'd2) begin
      fails++;
      $display("FAIL clear_pre: acc=%0d cnt=%0d, want 8 2", acc, cnt);
    end
    clear = 1'b1; drive(1'b1, 8'd7);
    cyc();
    clear = 1'b0;
    tests++;
    if (acc !== 12'd0 || cnt !== 3'd0 || in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL clear_accum: acc=%0d cnt=%0d ir=%b, want 0 0 1", acc, cnt, in_rdy);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'd1); cyc();
    end
    drive(1'b0, 8'h00);
    tests++;
    if (acc !== 12'd4 || out_vld !== 1'b1) begin
      fails++;
      $display("FAIL clear_post: acc=%0d ov=%b, want 4 1", acc, out_vld);
    end
    clear = 1'b1; out_ready = 1'b1;
    cyc();
    clear = 1'b0; out_ready = 1'b0;
    tests++;
    if (acc !== 12'd0 || cnt !== 3'd0 || out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL clear_hold: acc=%0d cnt=%0d ov=%b ir=%b, want 0 0 0 1", acc, cnt, out_vld, in_rdy);
    end
  endtask

  task automatic test_gaps();
    logic [6:0] pat = 7'b1101001;  // bit 0 first: 1,0,0,1,0,1,1
    int n = 0;
    for (int i = 0; i < 7; i++) begin
      drive(pat[i], pat[i] ? 8'd10 : 8'($urandom_range(0, 255)));
      if (pat[i]) n++;
      cyc();
      tests++;
      if (acc !== 12'(10*n) || cnt !== 3'(n) || out_vld !== (n == 4)) begin
        fails++;
        $display("FAIL gaps[%0d]: acc=%0d cnt=%0d ov=%b, want %0d %0d %b",
                 i, acc, cnt, out_vld, 10*n, n, n == 4);
      end
    end
    drive(1'b0, 8'h00);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'd5); cyc(); cyc();
    tests++;
    if (acc !== 12'd10 || cnt !== 3'd2) begin
      fails++;
      $display("FAIL rst_mid_pre: acc=%0d cnt=%0d, want 10 2", acc, cnt);
    end
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    tests++;
    if ({acc, cnt, ovf, out_vld, in_rdy} !== {12'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL rst_mid: acc=%0d cnt=%0d ovf=%b ov=%b ir=%b, want 0 0 0 0 1",
               acc, cnt, ovf, out_vld, in_rdy);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hFF); cyc();
    end
    tests++;
    if (acc !== 12'd1020 || out_vld !== 1'b1) begin
      fails++;
      $display("FAIL rst_hold_pre: acc=%0d ov=%b, want 1020 1", acc, out_vld);
    end
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    drive(1'b0, 8'h00);
    tests++;
    if ({acc, cnt, ovf, out_vld, in_rdy} !== {12'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL rst_hold: acc=%0d cnt=%0d ovf=%b ov=%b ir=%b, want 0 0 0 0 1",
               acc, cnt, ovf, out_vld, in_rdy);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; product_low = 4'h0; product_high = 4'h0;
    test_reset();
    test_burst();
    test_hold();
    test_wrap();
    test_clear();
    test_gaps();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
